stg_id: RTL and testbench

STG_ID -- requirements
Module: stg_id

---
 rtl/stg_id_pkg.sv | 119 +++++++++++
 rtl/id_decode.sv | 67 ++++++
 rtl/stg_id.sv | 93 +++++++++
 tb/tb_stg_id.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stg_id_pkg.sv
// Shared definitions for the ID stage: opcodes, condition codes, register indices,
// field widths, decode class and the registered stage record.
package stg_id_pkg;

    localparam int PC_W    = 48;
    localparam int INSTR_W = 24;
    localparam int OPC_W   = 8;
    localparam int CC_W    = 4;
    localparam int GP_W    = 4;
    localparam int AR_W    = 2;
    localparam int SR_W    = 2;
    localparam int CR_W    = 4;

    localparam logic [OPC_W-1:0] OPC_NOP     = 8'h00;
    localparam logic [OPC_W-1:0] OPC_ADD     = 8'h10;
    localparam logic [OPC_W-1:0] OPC_SUB     = 8'h11;
    localparam logic [OPC_W-1:0] OPC_AND     = 8'h12;
    localparam logic [OPC_W-1:0] OPC_OR      = 8'h13;
    localparam logic [OPC_W-1:0] OPC_XOR     = 8'h14;
    localparam logic [OPC_W-1:0] OPC_CMP     = 8'h18;
    localparam logic [OPC_W-1:0] OPC_TST     = 8'h19;
    localparam logic [OPC_W-1:0] OPC_ADDI    = 8'h20;
    localparam logic [OPC_W-1:0] OPC_ADDIs   = 8'h21;
    localparam logic [OPC_W-1:0] OPC_MOVI    = 8'h22;
    localparam logic [OPC_W-1:0] OPC_MOVIs   = 8'h23;
    localparam logic [OPC_W-1:0] OPC_CMPI    = 8'h28;
    localparam logic [OPC_W-1:0] OPC_CMPIs   = 8'h29;
    localparam logic [OPC_W-1:0] OPC_LDso    = 8'h30;
    localparam logic [OPC_W-1:0] OPC_STso    = 8'h31;
    localparam logic [OPC_W-1:0] OPC_SRJCCso = 8'hF0;
    localparam logic [OPC_W-1:0] OPC_SR2CR   = 8'hF4;

    localparam logic [CC_W-1:0] CC_AL = 4'h0;
    localparam logic [CC_W-1:0] CC_EQ = 4'h1;
    localparam logic [CC_W-1:0] CC_NE = 4'h2;

    localparam logic [SR_W-1:0] SR_IDX_LR  = 2'd0;
    localparam logic [SR_W-1:0] SR_IDX_SSP = 2'd1;
    localparam logic [SR_W-1:0] SR_IDX_FL  = 2'd2;
    localparam logic [SR_W-1:0] SR_IDX_PC  = 2'd3;

    localparam logic [CR_W-1:0] CR_FLD_CUR = 4'h0;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU_RR,
        CLS_ALU_IMM,
        CLS_LDST,
        CLS_SRJCC,
        CLS_SR2CR
    } dec_cls_e;

    typedef struct packed {
        logic            sgn_en;
        logic            imm_en;
        logic [15:0]     imm16;
        logic [13:0]     imm14;
        logic [11:0]     imm12;
        logic [9:0]      imm10;
        logic [CC_W-1:0] cc;
        logic            has_src_gp;
        logic [GP_W-1:0] src_gp;
        logic [GP_W-1:0] tgt_gp;
        logic            tgt_gp_we;
        logic            has_src_ar;
        logic [AR_W-1:0] src_ar;
        logic            has_tgt_ar;
        logic [AR_W-1:0] tgt_ar;
        logic            has_src_sr;
        logic [SR_W-1:0] src_sr;
        logic [SR_W-1:0] tgt_sr;
        logic            tgt_sr_we;
    } id_dec_t;

    localparam int ID_DEC_W = $bits(id_dec_t);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [OPC_W-1:0]   root_opc;
        logic [OPC_W-1:0]   opc;
        id_dec_t            dec;
    } id_stage_t;

    function automatic dec_cls_e opc_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
            OPC_CMP, OPC_TST:                         return CLS_ALU_RR;
            OPC_ADDI, OPC_ADDIs, OPC_MOVI, OPC_MOVIs,
            OPC_CMPI, OPC_CMPIs:                      return CLS_ALU_IMM;
            OPC_LDso, OPC_STso:                       return CLS_LDST;
            OPC_SRJCCso:                              return CLS_SRJCC;
            OPC_SR2CR:                                return CLS_SR2CR;
            default:                                  return CLS_NOP;
        endcase
    endfunction

    // Compare/test only set flags, so they never write a GP target.
    function automatic logic opc_no_gp_wb(input logic [OPC_W-1:0] opc);
        return (opc == OPC_CMP) || (opc == OPC_TST) ||
               (opc == OPC_CMPI) || (opc == OPC_CMPIs);
    endfunction

    function automatic logic opc_signed_imm(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADDIs) || (opc == OPC_MOVIs) || (opc == OPC_CMPIs);
    endfunction

    function automatic id_stage_t id_bubble(input logic [PC_W-1:0] pc);
        id_stage_t s;
        s          = '0;
        s.pc       = pc;
        s.instr    = {OPC_NOP, 16'h0000};
        s.root_opc = OPC_NOP;
        s.opc      = OPC_NOP;
        s.dec.cc   = CC_AL;
        return s;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode keyed on the root opcode; operand fields come
// from the low 16 instruction bits.
module id_decode
    import stg_id_pkg::*;
(
    input  logic [15:0]          instr_lo,
    input  logic [OPC_W-1:0]     root_opc,
    output logic [ID_DEC_W-1:0]  dec
);

    id_dec_t d;

    always_comb begin
        d       = '0;
        d.cc    = CC_AL;
        d.imm16 = instr_lo[15:0];
        d.imm14 = instr_lo[13:0];
        d.imm12 = instr_lo[11:0];
        d.imm10 = instr_lo[9:0];
        case (opc_class(root_opc))
            CLS_ALU_RR: begin
                d.tgt_gp     = instr_lo[15:12];
                d.src_gp     = instr_lo[11:8];
                d.has_src_gp = 1'b1;
                d.tgt_gp_we  = !opc_no_gp_wb(root_opc);
            end
            CLS_ALU_IMM: begin
                d.tgt_gp    = instr_lo[15:12];
                d.imm_en    = 1'b1;
                d.sgn_en    = opc_signed_imm(root_opc);
                d.tgt_gp_we = !opc_no_gp_wb(root_opc);
            end
            CLS_LDST: begin
                d.src_ar     = instr_lo[11:10];
                d.has_src_ar = 1'b1;
                d.imm_en     = 1'b1;
                d.sgn_en     = 1'b1;
                if (root_opc == OPC_LDso) begin
                    d.tgt_gp    = instr_lo[15:12];
                    d.tgt_gp_we = 1'b1;
                end else begin
                    d.src_gp     = instr_lo[15:12];
                    d.has_src_gp = 1'b1;
                end
            end
            CLS_SRJCC: begin
                // Branch target is applied downstream, so the SR write stays off.
                d.tgt_sr     = instr_lo[15:14];
                d.cc         = instr_lo[13:10];
                d.has_src_sr = 1'b1;
                d.src_sr     = SR_IDX_FL;
                d.imm_en     = 1'b1;
                d.sgn_en     = 1'b1;
            end
            CLS_SR2CR: begin
                d.tgt_ar     = instr_lo[15:14];
                d.has_tgt_ar = 1'b1;
                d.src_sr     = instr_lo[13:12];
                d.has_src_sr = 1'b1;
            end
            default: ;
        endcase
    end

    assign dec = d;

endmodule

// File: rtl/stg_id.sv
// ID pipeline register: decodes the IF/ID instruction and registers it with
// priority reset > flush > stall > load.
module stg_id
    import stg_id_pkg::*;
(
    input  logic        iw_clk,
    input  logic        iw_rst,
    input  logic [47:0] iw_pc,
    input  logic [23:0] iw_instr,
    input  logic [7:0]  iw_root_opc,
    input  logic        iw_flush,
    input  logic        iw_stall,
    output logic [47:0] ow_pc,
    output logic [23:0] ow_instr,
    output logic [7:0]  ow_root_opc,
    output logic [7:0]  ow_opc,
    output logic        ow_sgn_en,
    output logic        ow_imm_en,
    output logic [15:0] ow_imm16_val,
    output logic [13:0] ow_imm14_val,
    output logic [11:0] ow_imm12_val,
    output logic [9:0]  ow_imm10_val,
    output logic [3:0]  ow_cc,
    output logic        ow_has_src_gp,
    output logic [3:0]  ow_src_gp,
    output logic [3:0]  ow_tgt_gp,
    output logic        ow_tgt_gp_we,
    output logic        ow_has_src_ar,
    output logic [1:0]  ow_src_ar,
    output logic        ow_has_tgt_ar,
    output logic [1:0]  ow_tgt_ar,
    output logic        ow_has_src_sr,
    output logic [1:0]  ow_src_sr,
    output logic [1:0]  ow_tgt_sr,
    output logic        ow_tgt_sr_we
);

    logic [ID_DEC_W-1:0] dec_w;
    id_stage_t           stage_d;
    id_stage_t           stage_q;

    id_decode u_id_decode (
        .instr_lo (iw_instr[15:0]),
        .root_opc (iw_root_opc),
        .dec      (dec_w)
    );

    always_comb begin
        stage_d = stage_q;
        if (iw_flush) begin
            stage_d = id_bubble(iw_pc);
        end else if (!iw_stall) begin
            stage_d.pc       = iw_pc;
            stage_d.instr    = iw_instr;
            stage_d.root_opc = iw_root_opc;
            stage_d.opc      = iw_instr[23:16];
            stage_d.dec      = id_dec_t'(dec_w);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            stage_q <= id_bubble('0);
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ow_pc         = stage_q.pc;
    assign ow_instr      = stage_q.instr;
    assign ow_root_opc   = stage_q.root_opc;
    assign ow_opc        = stage_q.opc;
    assign ow_sgn_en     = stage_q.dec.sgn_en;
    assign ow_imm_en     = stage_q.dec.imm_en;
    assign ow_imm16_val  = stage_q.dec.imm16;
    assign ow_imm14_val  = stage_q.dec.imm14;
    assign ow_imm12_val  = stage_q.dec.imm12;
    assign ow_imm10_val  = stage_q.dec.imm10;
    assign ow_cc         = stage_q.dec.cc;
    assign ow_has_src_gp = stage_q.dec.has_src_gp;
    assign ow_src_gp     = stage_q.dec.src_gp;
    assign ow_tgt_gp     = stage_q.dec.tgt_gp;
    assign ow_tgt_gp_we  = stage_q.dec.tgt_gp_we;
    assign ow_has_src_ar = stage_q.dec.has_src_ar;
    assign ow_src_ar     = stage_q.dec.src_ar;
    assign ow_has_tgt_ar = stage_q.dec.has_tgt_ar;
    assign ow_tgt_ar     = stage_q.dec.tgt_ar;
    assign ow_has_src_sr = stage_q.dec.has_src_sr;
    assign ow_src_sr     = stage_q.dec.src_sr;
    assign ow_tgt_sr     = stage_q.dec.tgt_sr;
    assign ow_tgt_sr_we  = stage_q.dec.tgt_sr_we;

endmodule

// File: tb/tb_stg_id.sv
// Bench for stg_id: directed pipeline-control cases followed by random decode
// traffic, checked against an independent reference model via an expected queue.
module tb_stg_id;

    localparam int W = 168;

    localparam logic [7:0] T_NOP = 8'h00, T_ADD = 8'h10, T_SUB = 8'h11, T_AND = 8'h12,
                           T_OR = 8'h13, T_XOR = 8'h14, T_CMP = 8'h18, T_TST = 8'h19,
                           T_ADDI = 8'h20, T_ADDIS = 8'h21, T_MOVI = 8'h22, T_MOVIS = 8'h23,
                           T_CMPI = 8'h28, T_CMPIS = 8'h29, T_LD = 8'h30, T_ST = 8'h31,
                           T_SRJ = 8'hF0, T_S2C = 8'hF4;

    logic        iw_clk, iw_rst, iw_flush, iw_stall;
    logic [47:0] iw_pc;
    logic [23:0] iw_instr;
    logic [7:0]  iw_root_opc;
    logic [47:0] ow_pc;
    logic [23:0] ow_instr;
    logic [7:0]  ow_root_opc, ow_opc;
    logic        ow_sgn_en, ow_imm_en;
    logic [15:0] ow_imm16_val;
    logic [13:0] ow_imm14_val;
    logic [11:0] ow_imm12_val;
    logic [9:0]  ow_imm10_val;
    logic [3:0]  ow_cc, ow_src_gp, ow_tgt_gp;
    logic        ow_has_src_gp, ow_tgt_gp_we, ow_has_src_ar, ow_has_tgt_ar;
    logic        ow_has_src_sr, ow_tgt_sr_we;
    logic [1:0]  ow_src_ar, ow_tgt_ar, ow_src_sr, ow_tgt_sr;

    logic [W-1:0] obs_vec;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [7:0]   opc_tbl[18];

    stg_id dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_instr(iw_instr),
        .iw_root_opc(iw_root_opc), .iw_flush(iw_flush), .iw_stall(iw_stall),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_root_opc(ow_root_opc), .ow_opc(ow_opc),
        .ow_sgn_en(ow_sgn_en), .ow_imm_en(ow_imm_en), .ow_imm16_val(ow_imm16_val),
        .ow_imm14_val(ow_imm14_val), .ow_imm12_val(ow_imm12_val), .ow_imm10_val(ow_imm10_val),
        .ow_cc(ow_cc), .ow_has_src_gp(ow_has_src_gp), .ow_src_gp(ow_src_gp),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we), .ow_has_src_ar(ow_has_src_ar),
        .ow_src_ar(ow_src_ar), .ow_has_tgt_ar(ow_has_tgt_ar), .ow_tgt_ar(ow_tgt_ar),
        .ow_has_src_sr(ow_has_src_sr), .ow_src_sr(ow_src_sr), .ow_tgt_sr(ow_tgt_sr),
        .ow_tgt_sr_we(ow_tgt_sr_we)
    );

    assign obs_vec = {ow_pc, ow_instr, ow_root_opc, ow_opc, ow_sgn_en, ow_imm_en,
                      ow_imm16_val, ow_imm14_val, ow_imm12_val, ow_imm10_val, ow_cc,
                      ow_has_src_gp, ow_src_gp, ow_tgt_gp, ow_tgt_gp_we,
                      ow_has_src_ar, ow_src_ar, ow_has_tgt_ar, ow_tgt_ar,
                      ow_has_src_sr, ow_src_sr, ow_tgt_sr, ow_tgt_sr_we};

    // clock / reset
    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-class table.
    function automatic logic [W-1:0] model_load(input logic [47:0] pc, input logic [23:0] ins,
                                                input logic [7:0] root);
        logic       sgn, imm, hsg, tgwe, hsa, hta, hss, tswe;
        logic [3:0] cc, sg, tg;
        logic [1:0] sa, ta, ss, ts;
        {sgn, imm, hsg, tgwe, hsa, hta, hss, tswe} = '0;
        {cc, sg, tg, sa, ta, ss, ts} = '0;
        case (root)
            T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_CMP, T_TST: begin
                tg = ins[15:12]; sg = ins[11:8]; hsg = 1'b1;
                tgwe = (root != T_CMP) && (root != T_TST);
            end
            T_ADDI, T_ADDIS, T_MOVI, T_MOVIS, T_CMPI, T_CMPIS: begin
                tg = ins[15:12]; imm = 1'b1;
                sgn = (root == T_ADDIS) || (root == T_MOVIS) || (root == T_CMPIS);
                tgwe = (root != T_CMPI) && (root != T_CMPIS);
            end
            T_LD: begin
                sa = ins[11:10]; hsa = 1'b1; imm = 1'b1; sgn = 1'b1;
                tg = ins[15:12]; tgwe = 1'b1;
            end
            T_ST: begin
                sa = ins[11:10]; hsa = 1'b1; imm = 1'b1; sgn = 1'b1;
                sg = ins[15:12]; hsg = 1'b1;
            end
            T_SRJ: begin
                ts = ins[15:14]; cc = ins[13:10]; hss = 1'b1; ss = 2'd2;
                imm = 1'b1; sgn = 1'b1;
            end
            T_S2C: begin
                ta = ins[15:14]; hta = 1'b1; ss = ins[13:12]; hss = 1'b1;
            end
            default: ;
        endcase
        return {pc, ins, root, ins[23:16], sgn, imm, ins[15:0], ins[13:0], ins[11:0],
                ins[9:0], cc, hsg, sg, tg, tgwe, hsa, sa, hta, ta, hss, ss, ts, tswe};
    endfunction

    function automatic logic [W-1:0] model_bubble(input logic [47:0] pc);
        logic [W-1:0] v;
        v = '0;
        v[W-1 -: 48] = pc;
        return v;
    endfunction

    // driver: apply one cycle of inputs, push the expected output, compare after the edge
    task automatic drive(input logic [47:0] pc, input logic [23:0] ins, input logic [7:0] root,
                         input logic fl, input logic st, input logic rst_n, input string tag);
        logic [W-1:0] nxt, e;
        iw_pc = pc; iw_instr = ins; iw_root_opc = root;
        iw_flush = fl; iw_stall = st; iw_rst = rst_n;
        if (!rst_n)   nxt = model_bubble('0);
        else if (fl)  nxt = model_bubble(pc);
        else if (st)  nxt = model_q;
        else          nxt = model_load(pc, ins, root);
        model_q = nxt;
        exp_q.push_back(nxt);
        @(posedge iw_clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, W'(0), W'(1));
        end else begin
            e = exp_q.pop_front();
            check(tag, obs_vec, e);
        end
    endtask

    initial begin
        logic [7:0]  r;
        logic [23:0] ins;
        logic [47:0] pc;
        opc_tbl = '{T_NOP, T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_CMP, T_TST, T_ADDI,
                    T_ADDIS, T_MOVI, T_MOVIS, T_CMPI, T_CMPIS, T_LD, T_ST, T_SRJ, T_S2C};
        model_q = '0;

        drive(48'h1111, {T_ADD, 16'h1234}, T_ADD, 1'b0, 1'b0, 1'b0, "rst0");
        drive(48'h2222, {T_SRJ, 16'hFFFF}, T_SRJ, 1'b1, 1'b1, 1'b0, "rst1");
        check("rst_pc", W'(ow_pc), W'(0));
        check("rst_cc", W'(ow_cc), W'(0));

        drive(48'h1000, 24'h000000, T_NOP, 1'b0, 1'b0, 1'b1, "nop");
        check("nop_opc", W'(ow_opc), W'(8'h00));
        check("nop_en", W'({ow_imm_en, ow_sgn_en, ow_tgt_gp_we, ow_has_src_sr, ow_has_tgt_ar}), W'(0));

        drive(48'h1004, {T_SRJ, 2'd3, 4'h1, 10'd3}, T_SRJ, 1'b0, 1'b0, 1'b1, "srj");
        check("srj_f", W'({ow_has_src_sr, ow_src_sr, ow_tgt_sr, ow_tgt_sr_we, ow_imm10_val, ow_cc}),
              W'({1'b1, 2'd2, 2'd3, 1'b0, 10'd3, 4'h1}));

        drive(48'h1008, 24'h000000, T_NOP, 1'b0, 1'b1, 1'b1, "stall0");
        drive(48'h100C, 24'h000000, T_NOP, 1'b0, 1'b1, 1'b1, "stall1");
        check("stall_f", W'({ow_pc, ow_opc, ow_has_src_sr, ow_src_sr, ow_cc}),
              W'({48'h1004, 8'hF0, 1'b1, 2'd2, 4'h1}));

        drive(48'h1010, {T_S2C, 2'd2, 2'd1, 4'h0, 8'h00}, T_S2C, 1'b0, 1'b0, 1'b1, "s2c");
        check("s2c_f", W'({ow_has_src_sr, ow_src_sr, ow_has_tgt_ar, ow_tgt_ar, ow_tgt_sr_we, ow_tgt_gp_we}),
              W'({1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0}));

        drive(48'h1014, {T_S2C, 2'd2, 2'd1, 4'h0, 8'h00}, T_S2C, 1'b1, 1'b1, 1'b1, "flush");
        check("flush_f", W'({ow_pc, ow_instr, ow_has_src_sr, ow_has_tgt_ar}),
              W'({48'h1014, 24'h000000, 1'b0, 1'b0}));

        drive(48'h1018, {T_LD, 16'h5C07}, T_LD, 1'b0, 1'b0, 1'b1, "ld");
        check("ld_f", W'({ow_tgt_gp, ow_tgt_gp_we, ow_src_ar, ow_has_src_ar, ow_imm10_val}),
              W'({4'h5, 1'b1, 2'd3, 1'b1, 10'h007}));
        drive(48'h101C, {T_ST, 16'h5C07}, T_ST, 1'b0, 1'b1, 1'b0, "rst_stall");
        check("rst_stall_pc", W'(ow_pc), W'(0));

        for (int i = 0; i < 300; i++) begin
            r   = opc_tbl[$urandom_range(0, 17)];
            ins = {r, 16'($urandom)};
            if ($urandom_range(0, 9) == 0) r = 8'($urandom);
            pc  = {16'h0, 32'($urandom)};
            drive(pc, ins, r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 29) != 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
